// File: rtl/mem_align_unit_pkg.sv
// Shared encodings for the memory-stage alignment logic: decoder Mask and
// MemWrite codes plus the byte-lane index helper keyed on endianness.
package mem_align_unit_pkg;

    typedef enum logic [2:0] {
        MASK_LB  = 3'b000,
        MASK_LH  = 3'b001,
        MASK_LW  = 3'b010,
        MASK_LBU = 3'b011,
        MASK_LHU = 3'b100
    } mask_e;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_SB   = 2'b01,
        MW_SH   = 2'b10,
        MW_SW   = 2'b11
    } mem_write_e;

    // Byte offset within the word -> index of the 8-bit lane in a 32-bit bus.
    function automatic logic [1:0] lane_idx(input logic big_endian, input logic [1:0] off);
        return big_endian ? ~off : off;
    endfunction

endpackage

// File: rtl/mem_align_unit_load_extract.sv
// Load data extraction: selects the byte/halfword lane named by the offset and
// sign- or zero-extends it according to the load mask.
module mem_align_unit_load_extract
    import mem_align_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  mask,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[8*lane_idx(BIG_ENDIAN, off) +: 8];
        // Halfword at offset 0 sits in the upper half for big-endian.
        half_sel = (off[1] ^ BIG_ENDIAN) ? data[31:16] : data[15:0];
        case (mask)
            MASK_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MASK_LH:  result = {{16{half_sel[15]}}, half_sel};
            MASK_LW:  result = data;
            MASK_LBU: result = {24'h0, byte_sel};
            MASK_LHU: result = {16'h0, half_sel};
            default:  result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Memory-stage load/store alignment: store lane enables and replication,
// misalignment detection/reporting, and stall-stable load writeback data.
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int MISALIGN_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      ex_valid,
    input  logic [31:0]               ex_addr,
    input  logic [31:0]               ex_store_data,
    input  logic [1:0]                ex_mem_write,
    input  logic                      ex_mem_read,
    input  logic [2:0]                ex_mask,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_we,
    output logic [31:0]               dmem_din,
    input  logic [31:0]               dmem_dout,
    output logic [31:0]               wb_load_data,
    output logic                      wb_load_valid,
    output logic                      misalign,
    output logic [31:0]               misalign_addr,
    output logic [MISALIGN_CNT_W-1:0] misalign_cnt
);

    localparam logic [MISALIGN_CNT_W-1:0] CNT_ONE = MISALIGN_CNT_W'(1);

    logic        access, is_half, is_word, misaligned;
    logic [3:0]  we_lanes;
    logic        m_load;
    logic [2:0]  m_mask;
    logic [1:0]  m_off;
    logic [31:0] hold_q;
    logic        hold_v;
    logic [31:0] load_src;

    assign dmem_addr = {ex_addr[31:2], 2'b00};

    always_comb begin
        access     = ex_valid & (ex_mem_read | (ex_mem_write != MW_NONE));
        is_half    = (ex_mem_read & ((ex_mask == MASK_LH) | (ex_mask == MASK_LHU)))
                   | (ex_mem_write == MW_SH);
        is_word    = (ex_mem_read & (ex_mask == MASK_LW)) | (ex_mem_write == MW_SW);
        misaligned = access & ((is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00)));
    end

    always_comb begin
        we_lanes = 4'b0000;
        dmem_din = ex_store_data;
        case (ex_mem_write)
            MW_SB: begin
                we_lanes[lane_idx(BIG_ENDIAN, ex_addr[1:0])] = 1'b1;
                dmem_din = {4{ex_store_data[7:0]}};
            end
            MW_SH: begin
                we_lanes = (ex_addr[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
                dmem_din = {2{ex_store_data[15:0]}};
            end
            MW_SW:   we_lanes = 4'b1111;
            default: we_lanes = 4'b0000;
        endcase
        dmem_we = (ex_valid & ~stall & rst & ~misaligned) ? we_lanes : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_load        <= 1'b0;
            m_mask        <= 3'b000;
            m_off         <= 2'b00;
            hold_q        <= 32'h0;
            hold_v        <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= 32'h0;
            misalign_cnt  <= '0;
        end else if (!stall) begin
            m_load   <= ex_valid & ex_mem_read & ~misaligned;
            m_mask   <= ex_mask;
            m_off    <= ex_addr[1:0];
            hold_v   <= 1'b0;
            misalign <= misaligned;
            if (misaligned) begin
                misalign_addr <= ex_addr;
                if (misalign_cnt != '1)
                    misalign_cnt <= misalign_cnt + CNT_ONE;
            end
        end else begin
            // Capture the BRAM word once; it may change while the pipe is frozen.
            misalign <= 1'b0;
            if (!hold_v) begin
                hold_q <= dmem_dout;
                hold_v <= 1'b1;
            end
        end
    end

    assign load_src      = hold_v ? hold_q : dmem_dout;
    assign wb_load_valid = m_load;

    mem_align_unit_load_extract #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_load_extract (
        .data   (load_src),
        .off    (m_off),
        .mask   (m_mask),
        .result (wb_load_data)
    );

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: directed cases plus random traffic checked against
// a byte-oriented reference model of alignment, lanes and stall behaviour.
module tb_mem_align_unit;

    localparam bit BE = 1'b1;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, stall, ex_valid, ex_mem_read;
    logic [31:0]   ex_addr, ex_store_data, dmem_dout;
    logic [1:0]    ex_mem_write;
    logic [2:0]    ex_mask;
    logic [31:0]   dmem_addr, dmem_din, wb_load_data, misalign_addr;
    logic [3:0]    dmem_we;
    logic          wb_load_valid, misalign;
    logic [CW-1:0] misalign_cnt;

    always #5 clk = ~clk;

    mem_align_unit #(.BIG_ENDIAN(BE), .MISALIGN_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_mask(ex_mask), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .wb_load_data(wb_load_data), .wb_load_valid(wb_load_valid),
        .misalign(misalign), .misalign_addr(misalign_addr), .misalign_cnt(misalign_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          p_valid = 0;
    logic [2:0]  p_mask = 3'd0;
    logic [1:0]  p_off = 2'd0;
    bit          frz = 0, frz_valid = 0;
    logic [31:0] frz_data = 32'h0;
    bit          m_mis = 0;
    logic [31:0] m_maddr = 32'h0;
    int          m_cnt = 0;
    bit          cur_v;
    logic [31:0] cur_d;
    bit          d_r, d_st, d_v, d_rd, d_mis;
    logic [31:0] d_a;
    logic [2:0]  d_mk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [1:0] mw, input bit rd, input logic [2:0] mk);
        if (mw != 2'b00) return (mw == 2'b01) ? 1 : (mw == 2'b10) ? 2 : 4;
        if (rd) begin
            if (mk == 3'd2) return 4;
            if (mk == 3'd1 || mk == 3'd4) return 2;
        end
        return 1;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = BE ? (w >> (8 * (3 - k))) : (w >> (8 * k));
        return s[7:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] mk);
        int          sz;
        logic [31:0] v;
        logic [7:0]  b;
        if (mk > 3'd4) return 32'h0;
        sz = (mk == 3'd2) ? 4 : (mk == 3'd1 || mk == 3'd4) ? 2 : 1;
        v  = 32'h0;
        for (int i = 0; i < sz; i++) begin
            b = byte_at(w, (int'(off) + i) % 4);
            if (BE) v = (v << 8) | {24'h0, b};
            else    v = v | ({24'h0, b} << (8 * i));
        end
        if ((mk == 3'd0 || mk == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    function automatic logic [3:0] ref_we(input logic [31:0] a, input int sz);
        logic [3:0] we;
        int         k;
        we = 4'b0000;
        for (int i = 0; i < sz; i++) begin
            k = (int'(a[1:0]) + i) % 4;
            we[BE ? 3 - k : k] = 1'b1;
        end
        return we;
    endfunction

    task automatic drive(input bit r, input bit st, input bit v, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] mw, input bit rd,
                         input logic [2:0] mk, input logic [31:0] dout);
        int          sz;
        logic [3:0]  ewe;
        logic [31:0] edin;
        @(negedge clk);
        rst = r; stall = st; ex_valid = v; ex_addr = a; ex_store_data = d;
        ex_mem_write = mw; ex_mem_read = rd; ex_mask = mk; dmem_dout = dout;
        sz    = acc_size(mw, rd, mk);
        d_mis = v && (rd || mw != 2'b00) && ((a & (sz - 1)) != 0);
        ewe   = (r && v && !st && !d_mis && mw != 2'b00) ? ref_we(a, sz) : 4'b0000;
        edin  = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
        cur_v = frz ? frz_valid : p_valid;
        cur_d = frz ? frz_data : ref_load(dout, p_off, p_mask);
        #1;
        chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("dmem_we", {28'h0, dmem_we}, {28'h0, ewe});
        if (ewe != 4'b0000) chk("dmem_din", dmem_din, edin);
        chk("wb_load_valid", {31'h0, wb_load_valid}, {31'h0, cur_v});
        if (cur_v) chk("wb_load_data", wb_load_data, cur_d);
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
        chk("misalign_addr", misalign_addr, m_maddr);
        chk("misalign_cnt", {24'h0, misalign_cnt}, m_cnt);
        d_r = r; d_st = st; d_v = v; d_a = a; d_rd = rd; d_mk = mk;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!d_r) begin
            p_valid = 0; p_mask = 3'd0; p_off = 2'd0; frz = 0;
            m_mis = 0; m_maddr = 32'h0; m_cnt = 0;
        end else if (d_st) begin
            if (!frz) begin
                frz = 1; frz_valid = cur_v; frz_data = cur_d;
            end
            m_mis = 0;
        end else begin
            frz = 0;
            p_valid = d_v && d_rd && !d_mis;
            p_mask = d_mk; p_off = d_a[1:0];
            m_mis = d_mis;
            if (d_mis) begin
                m_maddr = d_a;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_addr = 32'h0; ex_store_data = 32'h0;
        ex_mem_write = 2'b00; ex_mem_read = 1'b0; ex_mask = 3'd0; dmem_dout = 32'h0;

        // Reset with a valid SW on the bus: no write may escape.
        drive(0, 0, 1, 32'h1000, 32'h5555_AAAA, 2'b11, 0, 3'd0, 32'h0);
        chk("rst_we", {28'h0, dmem_we}, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h0);
        chk("rst_cnt", {24'h0, misalign_cnt}, 32'h0);
        tick();

        drive(1, 0, 1, 32'h1001, 32'h0000_00AB, 2'b01, 0, 3'd0, 32'h0);
        chk("sb_we", {28'h0, dmem_we}, 32'h4);
        chk("sb_din", dmem_din, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr, 32'h1000);
        tick();

        drive(1, 0, 1, 32'h2003, 32'h0, 2'b00, 1, 3'd0, 32'h0);
        tick();
        drive(1, 0, 1, 32'h2003, 32'h0, 2'b00, 1, 3'd3, 32'h1234_5680);
        chk("lb_data", wb_load_data, 32'hFFFF_FF80);
        chk("lb_valid", {31'h0, wb_load_valid}, 32'h1);
        tick();
        drive(1, 0, 1, 32'h2002, 32'h0, 2'b00, 1, 3'd1, 32'h1234_5680);
        chk("lbu_data", wb_load_data, 32'h0000_0080);
        tick();
        drive(1, 0, 1, 32'h2000, 32'h0, 2'b00, 1, 3'd4, 32'h1234_8001);
        chk("lh_data", wb_load_data, 32'hFFFF_8001);
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h1234_8001);
        chk("lhu_data", wb_load_data, 32'h0000_1234);
        tick();

        drive(1, 0, 1, 32'h1002, 32'h1111_2222, 2'b11, 0, 3'd0, 32'h0);
        chk("sw_mis_we", {28'h0, dmem_we}, 32'h0);
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h0);
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_addr", misalign_addr, 32'h1002);
        chk("mis_cnt1", {24'h0, misalign_cnt}, 32'h1);
        tick();

        // LW then a 3-cycle stall with a misaligned LW waiting in EX.
        drive(1, 0, 1, 32'h3000, 32'h0, 2'b00, 1, 3'd2, 32'h0);
        tick();
        drive(1, 1, 1, 32'h3001, 32'h0, 2'b00, 1, 3'd2, 32'hCAFE_F00D);
        chk("stall_d0", wb_load_data, 32'hCAFE_F00D);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 32'h3001, 32'h0, 2'b00, 1, 3'd2, 32'hDEAD_BEEF);
            chk("stall_data", wb_load_data, 32'hCAFE_F00D);
            chk("stall_valid", {31'h0, wb_load_valid}, 32'h1);
            chk("stall_mis", {31'h0, misalign}, 32'h0);
            tick();
        end
        drive(1, 0, 1, 32'h3001, 32'h0, 2'b00, 1, 3'd2, 32'h1111_1111);
        chk("release_data", wb_load_data, 32'hCAFE_F00D);
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h0);
        chk("release_mis", {31'h0, misalign}, 32'h1);
        chk("release_cnt", {24'h0, misalign_cnt}, 32'h2);
        tick();

        // Reset in the cycle after a load issues.
        drive(1, 0, 1, 32'h2000, 32'h0, 2'b00, 1, 3'd2, 32'h0);
        tick();
        drive(0, 0, 1, 32'h1000, 32'h0, 2'b11, 0, 3'd0, 32'h7777_7777);
        tick();
        drive(0, 0, 1, 32'h1000, 32'h0, 2'b11, 0, 3'd0, 32'h7777_7777);
        chk("rst_ld_valid", {31'h0, wb_load_valid}, 32'h0);
        chk("rst_ld_cnt", {24'h0, misalign_cnt}, 32'h0);
        chk("rst_ld_we", {28'h0, dmem_we}, 32'h0);
        tick();

        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 1, 32'h1002, 32'h0, 2'b11, 0, 3'd0, 32'h0);
            tick();
        end
        drive(1, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h0);
        chk("cnt_sat", {24'h0, misalign_cnt}, 32'hFF);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3'd0, 32'h0);
        tick();

        for (int i = 0; i < 500; i++) begin
            int          kind;
            logic [1:0]  mw;
            kind = $urandom_range(0, 2);
            mw   = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(($urandom % 40) != 0, ($urandom % 4) == 0, ($urandom % 8) != 0,
                  $urandom, $urandom, mw, kind == 1, 3'($urandom_range(0, 7)), $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
